swim_tx: RTL
============

SWIM_TX -- requirements
Module: swim_tx

Interface
REQ-001 Parameter CYC_PER_UNIT, default 6, meaning clk cycles per SWIM time unit (48 MHz / 8 MHz).
REQ-002 Parameter UNITS_BIT, default 22, meaning SWIM time units per low-speed bit.
REQ-003 Parameter UNITS_SHORT, default 2, meaning short low/high phase length in units.
REQ-004 Parameter ACK_TIMEOUT, default 256, meaning units to wait for target ACK falling edge.
REQ-005 Port clk  input  1  single clock; all logic on posedge clk.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port in_data  input  8  payload; command in [2:0] when in_cmd=1.
REQ-008 Port in_cmd  input  1  1 = 3-bit command frame, 0 = 8-bit data frame.
REQ-009 Port in_valid  input  1  request valid.
REQ-010 Port in_ready  output  1  block can accept a request.
REQ-011 Port swim_oe  output  1  1 = drive SWIM line low (open-drain enable), 0 = release.
REQ-012 Port swim_in  input  1  raw SWIM line level, asynchronous.
REQ-013 Port ack_valid  output  1  one-cycle pulse: frame result available.
REQ-014 Port ack  output  1  1 = target ACK, 0 = NACK; valid with ack_valid.
REQ-015 Port timeout  output  1  1 = no target response within ACK_TIMEOUT; valid with ack_valid.

Function
REQ-016 Accept SHALL occur on a cycle with in_valid=1 and in_ready=1; in_data/in_cmd are latched that cycle.
REQ-017 in_ready SHALL be 1 only in state IDLE; in_valid held high in other states SHALL be ignored.
REQ-018 Frame SHALL be: start bit 0, payload MSB-first (3 or 8 bits), parity bit = XOR of payload bits; 5 bits (command) or 10 bits (data).
REQ-019 Bit 0: swim_oe=1 for (UNITS_BIT-UNITS_SHORT)*CYC_PER_UNIT cycles (120), then 0 for UNITS_SHORT*CYC_PER_UNIT cycles (12).
REQ-020 Bit 1: swim_oe=1 for 12 cycles, then 0 for 120 cycles; every bit is exactly 132 cycles.
REQ-021 swim_oe SHALL first assert on the cycle after accept; bits SHALL be back-to-back with no gap.
REQ-022 swim_in SHALL pass a 2-flop synchronizer; all edge detection and sampling use the synchronized value.
REQ-023 States: IDLE -> LOW (driving) -> HIGH (released) -> LOW of next bit ... -> after last HIGH -> WAIT_ACK -> SAMPLE_ACK -> DONE -> IDLE.
REQ-024 WAIT_ACK: swim_oe=0; detect synchronized falling edge; on edge go to SAMPLE_ACK.
REQ-025 SAMPLE_ACK: sample synchronized line (UNITS_BIT/2)*CYC_PER_UNIT cycles (66) after the edge; high -> ack=1, low -> ack=0.
REQ-026 If no falling edge within ACK_TIMEOUT*CYC_PER_UNIT cycles of entering WAIT_ACK, go to DONE with timeout=1, ack=0.
REQ-027 DONE: ack_valid=1 for exactly one cycle with ack/timeout; next cycle IDLE, in_ready=1.
REQ-028 ack and timeout SHALL hold their values until the next ack_valid.
REQ-029 Unit counter and bit counter widths SHALL cover the parameter maxima without wrap; the counter restarts at 0 at every phase change.
REQ-030 A falling edge seen in WAIT_ACK within the first synchronizer latency after release SHALL be ignored (the block's own release must not trigger it).

Reset
REQ-031 On reset: state IDLE, swim_oe=0, in_ready=1, ack_valid=0, ack=0, timeout=0, all counters 0, synchronizer flops 1.
REQ-032 Reset asserted mid-frame SHALL release the line (swim_oe=0) on the next clock edge and abandon the frame with no ack_valid.

Verification
REQ-033 Command in_cmd=1, in_data=8'h01, target ACK -> bits 0,0,0,1,1: swim_oe high 120/120/120/12/12 cycles per bit, frame 660 cycles, then ack_valid with ack=1, timeout=0.
REQ-034 Data in_data=8'hA5, in_cmd=0 -> bits 0,1,0,1,0,0,1,0,1,0 (parity 0), frame 1320 cycles; target NACK (line low at sample) -> ack=0.
REQ-035 No target response -> ack_valid exactly 1536 cycles after WAIT_ACK entry, timeout=1, ack=0.
REQ-036 in_valid held high continuously -> second frame accepted only the cycle after DONE; in_ready low throughout the frame.
REQ-037 Reset asserted in cycle 300 of a data frame -> swim_oe=0 next cycle, no ack_valid, in_ready=1; a following request completes normally.

Source files
------------

// File: rtl/swim_tx.sv
// SWIM low-speed transmitter: serialises one command or data frame onto the
// open-drain SWIM line, then waits for and samples the target ACK bit.
//
// state        | meaning
// S_IDLE       | line released, ready for a request
// S_LOW        | driving the low phase of the current bit
// S_HIGH       | released high phase of the current bit
// S_WAIT_ACK   | waiting for the target's falling edge, with timeout
// S_SAMPLE_ACK | counting to mid-bit, then sampling the ACK level
// S_DONE       | one-cycle result strobe
module swim_tx #(
   parameter int CYC_PER_UNIT = 6,
   parameter int UNITS_BIT    = 22,
   parameter int UNITS_SHORT  = 2,
   parameter int ACK_TIMEOUT  = 256
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_cmd,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       swim_oe,
   input  logic       swim_in,
   output logic       ack_valid,
   output logic       ack,
   output logic       timeout
);

   localparam int LONG_CYC  = (UNITS_BIT - UNITS_SHORT) * CYC_PER_UNIT;
   localparam int SHORT_CYC = UNITS_SHORT * CYC_PER_UNIT;
   localparam int HALF_CYC  = (UNITS_BIT / 2) * CYC_PER_UNIT;
   localparam int TO_CYC    = ACK_TIMEOUT * CYC_PER_UNIT;
   localparam int BIT_CYC   = UNITS_BIT * CYC_PER_UNIT;
   localparam int BLANK_CYC = 3;
   localparam int CNT_MAX   = (TO_CYC > BIT_CYC) ? TO_CYC : BIT_CYC;
   localparam int CW        = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_CYC - 1);
   localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_CYC - 1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);
   localparam logic [CW-1:0] TO_LAST    = CW'(TO_CYC - 1);
   localparam logic [CW-1:0] BLANK_CNT  = CW'(BLANK_CYC);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOW,
      S_HIGH,
      S_WAIT_ACK,
      S_SAMPLE_ACK,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_left;
   logic [9:0]    shreg;
   logic          sync_1;
   logic          sync_2;
   logic          sync_d;

   logic cur_bit;
   logic phase_end;
   logic fall_seen;

   assign cur_bit = shreg[9];

   // A 0 bit is a long low then short high; a 1 bit is the reverse.
   always_comb begin
      phase_end = 1'b0;
      case (state)
         S_LOW:   phase_end = cur_bit ? (cnt == SHORT_LAST) : (cnt == LONG_LAST);
         S_HIGH:  phase_end = cur_bit ? (cnt == LONG_LAST) : (cnt == SHORT_LAST);
         default: phase_end = 1'b0;
      endcase
   end

   // Blank the first few cycles so our own release cannot look like an ACK edge.
   assign fall_seen = sync_d & ~sync_2 & (cnt >= BLANK_CNT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_left  <= '0;
         shreg     <= '0;
         sync_1    <= 1'b1;
         sync_2    <= 1'b1;
         sync_d    <= 1'b1;
         swim_oe   <= 1'b0;
         in_ready  <= 1'b1;
         ack_valid <= 1'b0;
         ack       <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         sync_1    <= swim_in;
         sync_2    <= sync_1;
         sync_d    <= sync_2;
         ack_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (in_valid && in_ready) begin
                  if (in_cmd) begin
                     shreg    <= {1'b0, in_data[2:0], ^in_data[2:0], 5'b0};
                     bit_left <= 4'd4;
                  end else begin
                     shreg    <= {1'b0, in_data, ^in_data};
                     bit_left <= 4'd9;
                  end
                  state    <= S_LOW;
                  swim_oe  <= 1'b1;
                  in_ready <= 1'b0;
               end
            end

            S_LOW: begin
               if (phase_end) begin
                  state   <= S_HIGH;
                  swim_oe <= 1'b0;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_HIGH: begin
               if (phase_end) begin
                  cnt <= '0;
                  if (bit_left == 4'd0) begin
                     state <= S_WAIT_ACK;
                  end else begin
                     state    <= S_LOW;
                     swim_oe  <= 1'b1;
                     shreg    <= {shreg[8:0], 1'b0};
                     bit_left <= bit_left - 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_WAIT_ACK: begin
               swim_oe <= 1'b0;
               if (fall_seen) begin
                  state <= S_SAMPLE_ACK;
                  cnt   <= '0;
               end else if (cnt == TO_LAST) begin
                  state     <= S_DONE;
                  ack_valid <= 1'b1;
                  ack       <= 1'b0;
                  timeout   <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_SAMPLE_ACK: begin
               if (cnt == HALF_LAST) begin
                  state     <= S_DONE;
                  ack_valid <= 1'b1;
                  ack       <= sync_2;
                  timeout   <= 1'b0;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_DONE: begin
               state    <= S_IDLE;
               in_ready <= 1'b1;
               cnt      <= '0;
            end

            default: begin
               state    <= S_IDLE;
               swim_oe  <= 1'b0;
               in_ready <= 1'b1;
               cnt      <= '0;
            end
         endcase
      end
   end

endmodule
